// File: rtl/addr_gap_lut_mc_pkg.sv
// Shared widths, channel-index sizing and the pipeline sideband record
// for the multi-channel address-gap lookup engine.
package addr_gap_pkg;

    localparam int DEF_ANGLE_W  = 32;
    localparam int DEF_SIGN_BIT = 23;
    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_GAP_W    = 12;
    localparam int DEF_OFS_W    = 8;

    // Sideband carries the widest channel index so one record type fits every NUM_CH.
    localparam int MAX_CH_W = 4;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_CH_W-1:0] ch;
        logic                sign;
        logic                sat;
    } side_t;

endpackage

// File: rtl/addr_gap_lut_mc_if.sv
// Request and result bus between the angle sources, the lookup engine and the gap consumers.
interface addr_gap_lut_mc_if #(
    parameter int NUM_CH  = 4,
    parameter int ANGLE_W = addr_gap_pkg::DEF_ANGLE_W,
    parameter int GAP_W   = addr_gap_pkg::DEF_GAP_W,
    parameter int OFS_W   = addr_gap_pkg::DEF_OFS_W,
    parameter int CH_W    = addr_gap_pkg::ch_width(NUM_CH)
);
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*ANGLE_W-1:0] in_angle;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_valid;
    logic [CH_W-1:0]           out_ch;
    logic [GAP_W-1:0]          out_gap;
    logic [OFS_W-1:0]          out_offset;
    logic                      out_sign;
    logic                      out_sat;

    modport master (
        output in_valid, in_angle,
        input  in_ready, out_valid, out_ch, out_gap, out_offset, out_sign, out_sat
    );

    modport slave (
        input  in_valid, in_angle,
        output in_ready, out_valid, out_ch, out_gap, out_offset, out_sign, out_sat
    );
endinterface

// File: rtl/addr_gap_lut_mc_rom.sv
// Gap, positive-offset and negative-offset tables sharing one address,
// read through ROM_LAT register stages. Swapped for vendor ROM macros on silicon.
module gap_rom_bank #(
    parameter int    ADDR_W       = 11,
    parameter int    GAP_W        = 12,
    parameter int    OFS_W        = 8,
    parameter int    ROM_LAT      = 1,
    parameter string GAP_INIT     = "",
    parameter string OFS_POS_INIT = "",
    parameter string OFS_NEG_INIT = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [GAP_W-1:0]  gap,
    output logic [OFS_W-1:0]  ofs_pos,
    output logic [OFS_W-1:0]  ofs_neg
);

    localparam bit EXT_IMAGE = (GAP_INIT != "") || (OFS_POS_INIT != "") || (OFS_NEG_INIT != "");

    if (EXT_IMAGE) begin : g_ext_image
        // Image files are consumed by the vendor ROM wrapper; this model keeps its built-in contents.
    end

    function automatic logic [GAP_W-1:0] gap_word(input logic [ADDR_W-1:0] a);
        return GAP_W'(32'(a) * 32'd5 + 32'd3);
    endfunction

    function automatic logic [OFS_W-1:0] pos_word(input logic [ADDR_W-1:0] a);
        return OFS_W'(a) ^ OFS_W'(32'h5A);
    endfunction

    function automatic logic [OFS_W-1:0] neg_word(input logic [ADDR_W-1:0] a);
        return ~OFS_W'(a);
    endfunction

    logic [GAP_W-1:0] gap_pipe [ROM_LAT];
    logic [OFS_W-1:0] pos_pipe [ROM_LAT];
    logic [OFS_W-1:0] neg_pipe [ROM_LAT];

    always_ff @(posedge clk) begin
        gap_pipe[0] <= gap_word(addr);
        pos_pipe[0] <= pos_word(addr);
        neg_pipe[0] <= neg_word(addr);
        for (int i = 1; i < ROM_LAT; i++) begin
            gap_pipe[i] <= gap_pipe[i-1];
            pos_pipe[i] <= pos_pipe[i-1];
            neg_pipe[i] <= neg_pipe[i-1];
        end
    end

    assign gap     = gap_pipe[ROM_LAT-1];
    assign ofs_pos = pos_pipe[ROM_LAT-1];
    assign ofs_neg = neg_pipe[ROM_LAT-1];

endmodule

// File: rtl/addr_gap_lut_mc.sv
// Round-robin arbitrated angle-to-gap lookup: capture, sign-magnitude address
// with clamp, table read, registered tagged result.
module addr_gap_lut_mc
    import addr_gap_pkg::*;
#(
    parameter int    NUM_CH       = 4,
    parameter int    ANGLE_W      = DEF_ANGLE_W,
    parameter int    SIGN_BIT     = DEF_SIGN_BIT,
    parameter int    ADDR_W       = DEF_ADDR_W,
    parameter int    GAP_W        = DEF_GAP_W,
    parameter int    OFS_W        = DEF_OFS_W,
    parameter int    ROM_LAT      = 1,
    parameter string GAP_INIT     = "",
    parameter string OFS_POS_INIT = "",
    parameter string OFS_NEG_INIT = ""
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    output logic           busy,
    addr_gap_lut_mc_if.slave bus
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam int FW   = SIGN_BIT + 1;

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] sel;
    logic            found;
    logic [NUM_CH-1:0] grant;
    logic            accept;
    logic [FW-1:0]   sel_field;

    // Upper pass covers channels after rr_ptr, lower pass wraps around to the rest.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && bus.in_valid[i] && (CH_W'(i) > rr_ptr)) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && bus.in_valid[i]) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
    end

    always_comb begin
        grant     = '0;
        sel_field = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = found && (sel == CH_W'(i));
            if (sel == CH_W'(i)) sel_field = bus.in_angle[i*ANGLE_W +: FW];
        end
    end

    assign bus.in_ready = enable ? grant : '0;
    assign accept       = |(bus.in_valid & bus.in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= CH_W'(NUM_CH - 1);
        else if (accept) rr_ptr <= sel;
    end

    logic            c_valid;
    logic [CH_W-1:0] c_ch;
    logic [FW-1:0]   c_field;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_ch    <= '0;
            c_field <= '0;
        end else begin
            c_valid <= accept;
            if (accept) begin
                c_ch    <= sel;
                c_field <= sel_field;
            end
        end
    end

    logic              mag_sign;
    logic [FW-1:0]     mag;
    logic              clamp_sat;
    logic [ADDR_W-1:0] clamp_addr;

    always_comb begin
        mag_sign = c_field[FW-1];
        mag      = mag_sign ? (~c_field + FW'(1)) : c_field;
    end

    // The most negative field negates to itself, which still lands above the table and clamps.
    if (FW > ADDR_W) begin : g_clamp
        assign clamp_sat  = |mag[FW-1:ADDR_W];
        assign clamp_addr = clamp_sat ? '1 : mag[ADDR_W-1:0];
    end else begin : g_fit
        assign clamp_sat  = 1'b0;
        assign clamp_addr = ADDR_W'(mag);
    end

    side_t             a_side;
    logic [ADDR_W-1:0] a_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_side <= '0;
            a_addr <= '0;
        end else begin
            a_side <= '{valid: c_valid, ch: MAX_CH_W'(c_ch), sign: mag_sign, sat: clamp_sat};
            a_addr <= clamp_addr;
        end
    end

    logic [GAP_W-1:0] rom_gap;
    logic [OFS_W-1:0] rom_pos;
    logic [OFS_W-1:0] rom_neg;

    gap_rom_bank #(
        .ADDR_W      (ADDR_W),
        .GAP_W       (GAP_W),
        .OFS_W       (OFS_W),
        .ROM_LAT     (ROM_LAT),
        .GAP_INIT    (GAP_INIT),
        .OFS_POS_INIT(OFS_POS_INIT),
        .OFS_NEG_INIT(OFS_NEG_INIT)
    ) u_rom (
        .clk    (clk),
        .addr   (a_addr),
        .gap    (rom_gap),
        .ofs_pos(rom_pos),
        .ofs_neg(rom_neg)
    );

    side_t rom_side [ROM_LAT];
    side_t r_side;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) rom_side[i] <= '0;
        end else begin
            rom_side[0] <= a_side;
            for (int i = 1; i < ROM_LAT; i++) rom_side[i] <= rom_side[i-1];
        end
    end

    assign r_side = rom_side[ROM_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_ch     <= '0;
            bus.out_gap    <= '0;
            bus.out_offset <= '0;
            bus.out_sign   <= 1'b0;
            bus.out_sat    <= 1'b0;
        end else begin
            bus.out_valid <= r_side.valid;
            if (r_side.valid) begin
                bus.out_ch     <= CH_W'(r_side.ch);
                bus.out_gap    <= rom_gap;
                bus.out_offset <= r_side.sign ? rom_neg : rom_pos;
                bus.out_sign   <= r_side.sign;
                bus.out_sat    <= r_side.sat;
            end
        end
    end

    always_comb begin
        busy = c_valid | a_side.valid;
        for (int i = 0; i < ROM_LAT; i++) busy = busy | rom_side[i].valid;
    end

    // Angle bits above the field and spare channel-index bits are intentionally dropped.
    logic angle_unused;
    logic side_unused;
    assign angle_unused = ^bus.in_angle;
    assign side_unused  = ^r_side.ch;

endmodule

// File: tb/tb_addr_gap_lut_mc.sv
// Directed bench for addr_gap_lut_mc: expected results are queued on accept
// and checked by an independent monitor on every out_valid strobe.
module tb_addr_gap_lut_mc;
    import addr_gap_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int ANGLE_W = 32;
    localparam int GAP_W   = 12;
    localparam int OFS_W   = 8;
    localparam int CH_W    = ch_width(NUM_CH);
    localparam int LAT     = 4;

    typedef struct {
        int               cyc;
        logic [CH_W-1:0]  ch;
        logic [GAP_W-1:0] gap;
        logic [OFS_W-1:0] ofs;
        logic             sign;
        logic             sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic busy;

    addr_gap_lut_mc_if #(.NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W), .GAP_W(GAP_W), .OFS_W(OFS_W)) bus();

    addr_gap_lut_mc #(.NUM_CH(NUM_CH)) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc       = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   strobes   = 0;
    exp_t sb[$];
    exp_t pend[NUM_CH];
    logic [NUM_CH-1:0] hold_mask;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                strobes++;
                chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
                    chk("out_gap", 32'(bus.out_gap), 32'(e.gap));
                    chk("out_offset", 32'(bus.out_offset), 32'(e.ofs));
                    chk("out_sign", 32'(bus.out_sign), 32'(e.sign));
                    chk("out_sat", 32'(bus.out_sat), 32'(e.sat));
                end
            end
        end
    end

    task automatic set_req(input int ch, input logic [31:0] ang, input logic [GAP_W-1:0] g,
                           input logic [OFS_W-1:0] o, input logic s, input logic st);
        pend[ch] = '{cyc: 0, ch: CH_W'(ch), gap: g, ofs: o, sign: s, sat: st};
        bus.in_angle[ch*ANGLE_W +: ANGLE_W] = ang;
    endtask

    // Entered at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick(output logic [NUM_CH-1:0] acc);
        exp_t e;
        #1;
        acc = bus.in_valid & bus.in_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i]) begin
                e     = pend[i];
                e.cyc = cyc + LAT;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = bus.in_valid & ~(acc & ~hold_mask);
        @(negedge clk);
    endtask

    task automatic send(input int ch, input logic [31:0] ang, input logic [GAP_W-1:0] g,
                        input logic [OFS_W-1:0] o, input logic s, input logic st);
        logic [NUM_CH-1:0] acc;
        bit done;
        done = 1'b0;
        set_req(ch, ang, g, o, s, st);
        bus.in_valid[ch] = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            tick(acc);
            if (acc[ch]) done = 1'b1;
        end
        chk("send_grant", 32'(done), 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] acc;
        logic [NUM_CH-1:0] acc_or;

        rst          = 1'b1;
        enable       = 1'b0;
        hold_mask    = '0;
        bus.in_valid = '0;
        bus.in_angle = '0;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_out_gap", 32'(bus.out_gap), 32'd0);
        chk("rst_out_offset", 32'(bus.out_offset), 32'd0);
        chk("rst_out_sign", 32'(bus.out_sign), 32'd0);
        chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Address forming, sign and clamp corners.
        send(0, 32'h0000_0123, 12'h5B2, 8'h79, 1'b0, 1'b0);
        send(2, 32'h00FF_FEDD, 12'h5B2, 8'hDC, 1'b1, 1'b0);
        send(1, 32'h0000_0900, 12'h7FE, 8'hA5, 1'b0, 1'b1);
        send(0, 32'h0000_07FF, 12'h7FE, 8'hA5, 1'b0, 1'b0);
        send(1, 32'hAB00_0123, 12'h5B2, 8'h79, 1'b0, 1'b0);
        send(2, 32'h00FF_F801, 12'h7FE, 8'h00, 1'b1, 1'b0);
        send(3, 32'h0080_0000, 12'h7FE, 8'h00, 1'b1, 1'b1);
        drain();

        // Fairness: all channels continuously valid.
        set_req(0, 32'd1, 12'h008, 8'h5B, 1'b0, 1'b0);
        set_req(1, 32'd2, 12'h00D, 8'h58, 1'b0, 1'b0);
        set_req(2, 32'd3, 12'h012, 8'h59, 1'b0, 1'b0);
        set_req(3, 32'd4, 12'h017, 8'h5E, 1'b0, 1'b0);
        hold_mask    = '1;
        bus.in_valid = '1;
        for (int k = 0; k < 8; k++) begin
            tick(acc);
            chk("rr_grant", 32'(acc), 32'(1 << (k % 4)));
        end
        bus.in_valid = '0;
        hold_mask    = '0;
        bus.in_valid[1] = 1'b1;
        tick(acc);
        chk("rr_single", 32'(acc), 32'h2);
        drain();

        // Enable drop with three results in flight.
        send(0, 32'd1, 12'h008, 8'h5B, 1'b0, 1'b0);
        send(1, 32'd2, 12'h00D, 8'h58, 1'b0, 1'b0);
        send(2, 32'd3, 12'h012, 8'h59, 1'b0, 1'b0);
        strobes      = 0;
        enable       = 1'b0;
        hold_mask    = '1;
        bus.in_valid = '1;
        #1;
        chk("enable_ready_off", 32'(bus.in_ready), 32'd0);
        acc_or = '0;
        repeat (8) begin
            tick(acc);
            acc_or = acc_or | acc;
        end
        chk("enable_no_accept", 32'(acc_or), 32'd0);
        chk("enable_strobes", 32'(strobes), 32'd3);
        chk("enable_busy_idle", 32'(busy), 32'd0);
        bus.in_valid = '0;
        hold_mask    = '0;
        enable       = 1'b1;
        @(negedge clk);

        // Reset with two requests in flight.
        send(1, 32'd4, 12'h017, 8'h5E, 1'b0, 1'b0);
        send(2, 32'h0000_0123, 12'h5B2, 8'h79, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("mid_rst_out_gap", 32'(bus.out_gap), 32'd0);
        chk("mid_rst_out_offset", 32'(bus.out_offset), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        strobes = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_req(0, 32'h0000_0123, 12'h5B2, 8'h79, 1'b0, 1'b0);
        set_req(3, 32'h0000_0900, 12'h7FE, 8'hA5, 1'b0, 1'b1);
        bus.in_valid = 4'b1001;
        tick(acc);
        chk("post_rst_grant0", 32'(acc), 32'h1);
        tick(acc);
        chk("post_rst_grant3", 32'(acc), 32'h8);
        drain();
        chk("post_rst_strobes", 32'(strobes), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/addr_gap_lut_mc.md
# addr_gap_lut_mc

Multi-channel, parametrised angle-to-address-gap lookup engine. Up to NUM_CH requesters present signed angle words. A round-robin arbiter feeds them one per cycle into a shared pipeline that forms a sign-magnitude table address, saturates out-of-range magnitudes, and reads the gap, positive-offset and negative-offset tables. Each result leaves on one tagged output bus with the sign and saturation carried through the pipeline. It sits between the per-channel OPA angle sources and the address-gap consumers, and replaces the single-channel gap generator.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (1..16)
- ANGLE_W, 32, input angle word width
- SIGN_BIT, 23, bit index of the angle field sign; field is angle[SIGN_BIT:0]; requires SIGN_BIT < ANGLE_W
- ADDR_W, 11, table address width; depth = 2^ADDR_W
- GAP_W, 12, gap table data width
- OFS_W, 8, offset table data width
- ROM_LAT, 1, table read latency in cycles (>= 1)
- GAP_INIT / OFS_POS_INIT / OFS_NEG_INIT, "", memory init file names

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-high
- enable  in  1  admits new requests; in-flight work always completes
- in_valid  in  NUM_CH  per-channel request valid
- in_angle  in  NUM_CH*ANGLE_W  channel i occupies bits [i*ANGLE_W +: ANGLE_W]
- in_ready  out  NUM_CH  one-hot (or zero) accept
- out_valid  out  1  single-cycle result strobe
- out_ch  out  CH_W  channel of the result; CH_W = max(1, clog2(NUM_CH))
- out_gap  out  GAP_W  gap table word
- out_offset  out  OFS_W  offset word, taken from the positive or negative table by sign
- out_sign  out  1  1 = angle field was negative
- out_sat  out  1  1 = magnitude clamped
- busy  out  1  any request in flight

## Operation
- Arbiter: rr_ptr holds the last granted channel, reset value NUM_CH-1. Grant goes to the first channel with in_valid set, searching upward from rr_ptr+1 with wrap. in_ready[i] = enable & grant[i]. This path is combinational from in_valid. rr_ptr updates only on an accept.
- Accept: in_valid[i] & in_ready[i]. At most one accept per cycle. A channel holds its in_valid and in_angle until accepted.
- Stage C (capture): registers angle field, channel, valid.
- Stage A (address):
  - sign = field[SIGN_BIT].
  - mag = sign ? (~field + 1) : field, computed at width SIGN_BIT+1.
  - If mag > 2^ADDR_W-1: addr = all ones, sat = 1. Otherwise addr = mag[ADDR_W-1:0], sat = 0.
  - The most negative field (only SIGN_BIT set) gives sat = 1 and sign = 1.
  - Angle bits above SIGN_BIT are ignored.
- Table stage: three tables read at addr in parallel. Sign, sat, ch and valid are delayed ROM_LAT cycles alongside them.
- Output stage: registers gap, offset (neg table if sign, else pos), sign, sat, ch, and valid into out_*.
- The offset mux uses the pipelined sign, never a live input.
- busy = OR of all pipeline valid bits.
- enable low: in_ready = 0; results already in flight still emit.

## Timing
- Reset values: out_valid 0, out_ch 0, out_gap 0, out_offset 0, out_sign 0, out_sat 0, busy 0, all pipeline valids 0, rr_ptr NUM_CH-1.
- Latency: a request accepted in cycle c gives out_valid high for exactly cycle c+ROM_LAT+3 (default: c+4).
- Throughput: one result per cycle sustained. There is no output backpressure, so consumers must take out_* on the strobe.
- Payload out_* holds its last value while out_valid is low.
- Reset mid-operation: all in-flight requests are dropped and no out_valid follows. After reset release, the first grant goes to channel 0.
- enable falling in the same cycle as in_valid: no accept.

## Structure
- Package addr_gap_pkg holds:
  - the CH_W function;
  - default width constants (ANGLE_W, SIGN_BIT, ADDR_W, GAP_W, OFS_W);
  - the pipeline sideband record type {valid, ch, sign, sat}.
- Sub-module gap_rom_bank holds the three tables on one address, with ROM_LAT register stages. It is the only technology-specific part.

## Test plan
- Defaults. Angle 0x0000_0123 on ch0 → 4 cycles later: out_ch 0, gap = GAP[0x123], offset = OFS_POS[0x123], sign 0, sat 0.
- Angle 0x00FF_FEDD on ch2 → mag 0x123: sign 1, offset = OFS_NEG[0x123], sat 0.
- Saturation:
  - Angle 0x0000_0900 → addr 0x7FF, sat 1, sign 0.
  - Angle 0x0080_0000 → addr 0x7FF, sat 1, sign 1.
  - Angle 0x0000_07FF → sat 0.
- Fairness. All 4 channels valid for 8 cycles → grants 0,1,2,3,0,1,2,3. Back-to-back out_valid with out_ch in the same order. Afterwards, ch1 alone valid → grant ch1 next cycle.
- enable dropped with 3 requests in flight → in_ready 0 at once, exactly 3 further strobes, then busy 0.
- rst asserted with 2 requests in flight → all outputs 0 immediately, no strobe after release. First grant after release goes to channel 0.
